// File: rtl/cmd_intake_queue.sv
// cmd_intake_queue: in-order host command FIFO with per-bank issue gating and read tag tracking.
// Define CMD_QUEUE_STAT_EN to add saturating write/read/stall statistics counters.
module cmd_intake_queue #(
    parameter int CMD_W    = 34,
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 8,
    parameter int RD_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      power_on_rst_n,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic [CMD_W-1:0]          host_command,
    input  logic [DATA_W-1:0]         host_write_data,
    input  logic [7:0]                ba_cmd_pm,
    output logic [CMD_W-1:0]          command,
    output logic [DATA_W-1:0]         write_data,
    output logic                      valid,
    input  logic                      read_data_valid,
    output logic [CMD_W-1:0]          rd_tag,
    output logic                      rd_tag_valid,
    output logic [$clog2(RD_DEPTH):0] rd_outstanding,
    output logic                      rd_underflow
`ifdef CMD_QUEUE_STAT_EN
   ,output logic [31:0]               stat_wr_cnt,
    output logic [31:0]               stat_rd_cnt,
    output logic [31:0]               stat_stall_cnt
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int RPW = $clog2(RD_DEPTH);

    logic [CMD_W-1:0]  cmd_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    logic [CMD_W-1:0]  tag_mem [RD_DEPTH];
    logic [RPW-1:0]    tag_wr_ptr;
    logic [RPW-1:0]    tag_rd_ptr;
    logic [RPW:0]      tag_count;

    logic              push;
    logic              issue;
    logic              tag_push;
    logic              tag_pop;
    logic              tag_full;
    logic              tag_empty;
    logic [CMD_W-1:0]  head_cmd;
    logic [DATA_W-1:0] head_data;
    logic              head_is_read;
    logic [2:0]        head_bank;

    // Depths are powers of two, so the count MSB alone marks "full".
    assign host_ready   = ~count[PW];
    assign push         = host_valid & host_ready;

    assign head_cmd     = cmd_mem[rd_ptr];
    assign head_data    = data_mem[rd_ptr];
    assign head_is_read = head_cmd[31];
    assign head_bank    = head_cmd[2:0];

    assign tag_full     = tag_count[RPW];
    assign tag_empty    = (tag_count == '0);

    // A read head waits for a free tag slot so every returned beat can be identified.
    assign issue        = (count != '0) && ba_cmd_pm[head_bank] && !(head_is_read && tag_full);
    assign tag_push     = issue & head_is_read;
    assign tag_pop      = read_data_valid & ~tag_empty;

    assign rd_tag_valid   = tag_pop;
    assign rd_tag         = tag_pop ? tag_mem[tag_rd_ptr] : '0;
    assign rd_outstanding = tag_count;

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr]  <= host_command;
            data_mem[wr_ptr] <= host_write_data;
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            command    <= '0;
            write_data <= '0;
            valid      <= 1'b0;
        end else begin
            valid      <= issue;
            command    <= issue ? head_cmd : '0;
            write_data <= (issue && !head_is_read) ? head_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= head_cmd;
        end
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            tag_wr_ptr   <= '0;
            tag_rd_ptr   <= '0;
            tag_count    <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr <= tag_wr_ptr + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
            if (read_data_valid && tag_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

`ifdef CMD_QUEUE_STAT_EN
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            stat_wr_cnt    <= '0;
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (issue && !head_is_read && stat_wr_cnt != 32'hFFFF_FFFF) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end
            if (tag_push && stat_rd_cnt != 32'hFFFF_FFFF) begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
            if ((count != '0) && !issue && stat_stall_cnt != 32'hFFFF_FFFF) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_intake_queue.sv
// tb_cmd_intake_queue: directed table, corner sequences and random traffic against a queue-based model.
module tb_cmd_intake_queue;

    logic         clk = 1'b0;
    logic         power_on_rst_n = 1'b1;
    logic         host_valid = 1'b0;
    logic         host_ready;
    logic [33:0]  host_command = '0;
    logic [127:0] host_write_data = '0;
    logic [7:0]   ba_cmd_pm = '0;
    logic [33:0]  command;
    logic [127:0] write_data;
    logic         valid;
    logic         read_data_valid = 1'b0;
    logic [33:0]  rd_tag;
    logic         rd_tag_valid;
    logic [4:0]   rd_outstanding;
    logic         rd_underflow;

    always #5 clk = ~clk;

    cmd_intake_queue dut (
        .clk             (clk),
        .power_on_rst_n  (power_on_rst_n),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_command    (host_command),
        .host_write_data (host_write_data),
        .ba_cmd_pm       (ba_cmd_pm),
        .command         (command),
        .write_data      (write_data),
        .valid           (valid),
        .read_data_valid (read_data_valid),
        .rd_tag          (rd_tag),
        .rd_tag_valid    (rd_tag_valid),
        .rd_outstanding  (rd_outstanding),
        .rd_underflow    (rd_underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues of accepted commands and outstanding read tags.
    logic [33:0]  m_cmd  [$];
    logic [127:0] m_data [$];
    logic [33:0]  m_tag  [$];
    logic         m_under = 1'b0;

    typedef struct {
        logic         hv;
        logic [33:0]  cmd;
        logic [127:0] data;
        logic [7:0]   ba;
        logic         rdv;
        logic         e_valid;
        logic [33:0]  e_cmd;
        logic [127:0] e_data;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [33:0] mkCmd(input logic rw, input int bank, input int row, input int col);
        logic [33:0] c;
        c        = '0;
        c[31]    = rw;
        c[29:17] = row[12:0];
        c[12:3]  = col[9:0];
        c[2:0]   = bank[2:0];
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic applyStimulus(input logic hv, input logic [33:0] hc, input logic [127:0] hd,
                                 input logic [7:0] ba, input logic rdv);
        logic         exp_ready;
        logic         tpop;
        logic         iss;
        logic [33:0]  exp_tag;
        logic [33:0]  head;
        logic [127:0] hdata;
        logic         e_valid;
        logic [33:0]  e_cmd;
        logic [127:0] e_data;
        host_valid      = hv;
        host_command    = hc;
        host_write_data = hd;
        ba_cmd_pm       = ba;
        read_data_valid = rdv;
        #1;
        exp_ready = (m_cmd.size() < 8);
        tpop      = rdv && (m_tag.size() > 0);
        exp_tag   = tpop ? m_tag[0] : '0;
        checkOutput("host_ready", host_ready, exp_ready);
        checkOutput("rd_tag_valid", rd_tag_valid, tpop);
        checkOutput("rd_tag", rd_tag, exp_tag);
        iss = 1'b0;
        if (m_cmd.size() > 0) begin
            head = m_cmd[0];
            iss  = ba[head[2:0]] && !(head[31] && m_tag.size() == 16);
        end
        if (rdv && m_tag.size() == 0) m_under = 1'b1;
        if (tpop) void'(m_tag.pop_front());
        e_valid = iss;
        e_cmd   = '0;
        e_data  = '0;
        if (iss) begin
            head  = m_cmd.pop_front();
            hdata = m_data.pop_front();
            e_cmd = head;
            if (head[31]) m_tag.push_back(head);
            else          e_data = hdata;
        end
        if (hv && exp_ready) begin
            m_cmd.push_back(hc);
            m_data.push_back(hd);
        end
        @(posedge clk);
        #1;
        checkOutput("valid", valid, e_valid);
        checkOutput("command", command, e_cmd);
        checkOutput("write_data", write_data, e_data);
        checkOutput("rd_outstanding", rd_outstanding, m_tag.size());
        checkOutput("rd_underflow", rd_underflow, m_under);
    endtask

    task automatic idle(input logic [7:0] ba, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, ba, 1'b0);
    endtask

    task automatic doReset();
        host_valid      = 1'b0;
        read_data_valid = 1'b0;
        ba_cmd_pm       = 8'h00;
        power_on_rst_n  = 1'b0;
        #1;
        checkOutput("rst valid", valid, 1'b0);
        checkOutput("rst command", command, '0);
        checkOutput("rst write_data", write_data, '0);
        checkOutput("rst rd_outstanding", rd_outstanding, '0);
        checkOutput("rst rd_underflow", rd_underflow, 1'b0);
        checkOutput("rst rd_tag_valid", rd_tag_valid, 1'b0);
        checkOutput("rst rd_tag", rd_tag, '0);
        m_cmd.delete();
        m_data.delete();
        m_tag.delete();
        m_under = 1'b0;
        @(negedge clk);
        power_on_rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst host_ready", host_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [33:0]  c1, w2, w0, r0, r1, r2, ninth, rd17;
        logic [127:0] a5, d2, d0;
        logic [63:0]  rnd;
        int           vcount;

        c1 = mkCmd(1'b0, 0, 3, 8);
        w2 = mkCmd(1'b0, 2, 5, 16);
        w0 = mkCmd(1'b0, 0, 6, 24);
        a5 = {16{8'hA5}};
        d2 = {4{32'hD2D2_0002}};
        d0 = {4{32'hD0D0_0000}};

        vecs[0]  = '{1'b1, c1,  a5,  8'hFF, 1'b0, 1'b0, '0, '0};
        vecs[1]  = '{1'b0, '0,  '0,  8'hFF, 1'b0, 1'b1, c1, a5};
        vecs[2]  = '{1'b0, '0,  '0,  8'hFF, 1'b0, 1'b0, '0, '0};
        vecs[3]  = '{1'b1, w2,  d2,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[4]  = '{1'b1, w0,  d0,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[5]  = '{1'b0, '0,  '0,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[6]  = '{1'b0, '0,  '0,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[7]  = '{1'b0, '0,  '0,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[8]  = '{1'b0, '0,  '0,  8'hFB, 1'b0, 1'b0, '0, '0};
        vecs[9]  = '{1'b0, '0,  '0,  8'hFF, 1'b0, 1'b1, w2, d2};
        vecs[10] = '{1'b0, '0,  '0,  8'hFF, 1'b0, 1'b1, w0, d0};
        vecs[11] = '{1'b0, '0,  '0,  8'hFF, 1'b0, 1'b0, '0, '0};

        #2;
        doReset();

        $display("[TB] directed table: single write and bank stall");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].hv, vecs[i].cmd, vecs[i].data, vecs[i].ba, vecs[i].rdv);
            checkOutput("vec valid", valid, vecs[i].e_valid);
            checkOutput("vec command", command, vecs[i].e_cmd);
            checkOutput("vec write_data", write_data, vecs[i].e_data);
        end

        $display("[TB] full queue backpressure");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, mkCmd(1'b0, i % 8, i + 1, i), {4{32'(i)}}, 8'h00, 1'b0);
            if (i == 7) checkOutput("ready after 8th", host_ready, 1'b0);
        end
        checkOutput("ready with 9th held", host_ready, 1'b0);
        ninth  = mkCmd(1'b0, 0, 9, 8);
        vcount = 0;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(j < 2, ninth, {4{32'h9}}, 8'hFF, 1'b0);
            if (j < 9) vcount += int'(valid);
            if (j == 8) checkOutput("ninth issued last", command, ninth);
        end
        checkOutput("consecutive valids", vcount, 9);
        checkOutput("idle after drain", valid, 1'b0);

        $display("[TB] read tags in issue order");
        r0 = mkCmd(1'b1, 0, 1, 0);
        r1 = mkCmd(1'b1, 1, 2, 8);
        r2 = mkCmd(1'b1, 3, 15, 56);
        applyStimulus(1'b1, r0, '0, 8'hFF, 1'b0);
        applyStimulus(1'b1, r1, '0, 8'hFF, 1'b0);
        applyStimulus(1'b1, r2, '0, 8'hFF, 1'b0);
        idle(8'hFF, 2);
        checkOutput("outstanding 3", rd_outstanding, 3);
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("outstanding 2", rd_outstanding, 2);
        checkOutput("second tag", rd_tag, r1);
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("outstanding 1", rd_outstanding, 1);
        checkOutput("third tag", rd_tag, r2);
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("outstanding 0", rd_outstanding, 0);
        checkOutput("no tag left", rd_tag_valid, 1'b0);
        checkOutput("underflow stays clear", rd_underflow, 1'b0);

        $display("[TB] underflow and full tag FIFO");
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("underflow set", rd_underflow, 1'b1);
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, mkCmd(1'b1, k % 8, k, k), '0, 8'hFF, 1'b0);
        rd17 = mkCmd(1'b1, 0, 16, 16);
        idle(8'hFF, 4);
        checkOutput("17th stalled", valid, 1'b0);
        checkOutput("outstanding 16", rd_outstanding, 16);
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("after return", rd_outstanding, 15);
        applyStimulus(1'b0, '0, '0, 8'hFF, 1'b0);
        checkOutput("17th issued", valid, 1'b1);
        checkOutput("17th command", command, rd17);
        checkOutput("refilled", rd_outstanding, 16);
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, '0, '0, 8'hFF, 1'b1);
        checkOutput("drained", rd_outstanding, 0);
        checkOutput("underflow sticky", rd_underflow, 1'b1);

        $display("[TB] reset mid-stream");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, mkCmd(1'b1, k, k, k), '0, 8'hFF, 1'b0);
        idle(8'hFF, 2);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, mkCmd(1'b0, k, k, k), {4{32'(k)}}, 8'h00, 1'b0);
        checkOutput("pre-reset outstanding", rd_outstanding, 3);
        doReset();
        idle(8'hFF, 4);
        checkOutput("no stale valid", valid, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            logic [33:0] rc;
            if (i == 700) doReset();
            rnd    = {$urandom, $urandom};
            rc     = rnd[33:0];
            rc[30] = 1'b0;
            rc[16] = 1'b0;
            rc[14] = 1'b0;
            applyStimulus($urandom_range(0, 9) < 6, rc, {$urandom, $urandom, $urandom, $urandom},
                          ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF,
                          $urandom_range(0, 99) < 35);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
